// File: rtl/axi_slave_full_mem.sv
// axi_slave_full_mem
// AXI4 (full) slave in front of a C_MEM_WORDS x 32-bit byte-addressed memory.
// Supports INCR and FIXED bursts of 32-bit beats, with one outstanding write
// burst and one outstanding read burst. The two bursts run concurrently.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : clock (rising edge) and async active-low reset
//   AW / W / B                 : write address, write data, write response
//   AR / R                     : read address, read data
//
// Responses:
//   SLVERR - unsupported burst type or size, or a write whose WLAST beat
//            count differs from AWLEN+1.
//   DECERR - a beat addressed at or above C_MEM_WORDS*4.
//   SLVERR takes precedence over DECERR.
//
// All channel outputs are registered. READY outputs depend only on FSM state.
module axi_slave_full_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_WORDS        = 1024
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [2:0]                    S_AXI_AWSIZE,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W = $clog2(C_MEM_WORDS);
    // One extra bit so that C_MEM_WORDS*4 is representable for any address width.
    localparam logic [AW:0]   MEM_BYTES   = (AW+1)'(C_MEM_WORDS * 4);
    localparam logic [AW-1:0] BEAT_BYTES  = AW'(4);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [1:0]    RESP_DECERR = 2'b11;
    localparam logic [1:0]    BURST_FIXED = 2'b00;
    localparam logic [1:0]    BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // A request is unsupported unless it is an INCR/FIXED burst of 4-byte beats.
    function automatic logic req_bad(input logic [1:0] burst, input logic [2:0] size);
        return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size != 3'b010);
    endfunction

    function automatic logic addr_oor(input logic [AW-1:0] a);
        return {1'b0, a} >= MEM_BYTES;
    endfunction

    // FIXED holds the address; INCR steps one word and may wrap at the top of the address space.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] burst);
        return (burst == BURST_INCR) ? (a + BEAT_BYTES) : a;
    endfunction

    logic [31:0] mem [C_MEM_WORDS];

    // Write side state
    w_state_t                    w_state_r;
    logic [AW-1:0]               awaddr_r;
    logic [7:0]                  awlen_r;
    logic [1:0]                  awburst_r;
    logic [7:0]                  wbeat_r;
    logic                        wbad_r;
    logic                        wdec_r;
    logic                        wlen_over_r;
    logic                        awready_r;
    logic                        wready_r;
    logic                        bvalid_r;
    logic [1:0]                  bresp_r;
    logic [C_S_AXI_ID_WIDTH-1:0] bid_r;
    logic                        w_hs_s;
    logic                        w_oor_s;
    logic                        mem_we_s;

    // Read side state
    r_state_t                    r_state_r;
    logic [AW-1:0]               araddr_r;      // address of the next beat to load
    logic [7:0]                  arlen_r;
    logic [1:0]                  arburst_r;
    logic [7:0]                  rbeat_r;       // index of the beat currently presented
    logic                        rbad_r;
    logic                        arready_r;
    logic                        rvalid_r;
    logic                        rlast_r;
    logic [1:0]                  rresp_r;
    logic [31:0]                 rdata_r;
    logic [C_S_AXI_ID_WIDTH-1:0] rid_r;
    logic [AW-1:0]               ld_addr_s;
    logic [1:0]                  ld_burst_s;
    logic                        ld_bad_s;
    logic                        ld_oor_s;
    logic [31:0]                 ld_word_s;
    logic [31:0]                 ld_data_s;
    logic [1:0]                  ld_resp_s;

    assign w_hs_s   = wready_r & S_AXI_WVALID;
    assign w_oor_s  = addr_oor(awaddr_r);
    assign mem_we_s = w_hs_s & ~wbad_r & ~w_oor_s;

    // Write FSM: AW capture, W beat accounting, and B response generation.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_r   <= W_IDLE;
            awaddr_r    <= '0;
            awlen_r     <= 8'd0;
            awburst_r   <= 2'b00;
            wbeat_r     <= 8'd0;
            wbad_r      <= 1'b0;
            wdec_r      <= 1'b0;
            wlen_over_r <= 1'b0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bresp_r     <= 2'b00;
            bid_r       <= '0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    awready_r <= 1'b1;
                    if (awready_r && S_AXI_AWVALID) begin
                        awaddr_r    <= S_AXI_AWADDR;
                        awlen_r     <= S_AXI_AWLEN;
                        awburst_r   <= S_AXI_AWBURST;
                        wbad_r      <= req_bad(S_AXI_AWBURST, S_AXI_AWSIZE);
                        wdec_r      <= 1'b0;
                        wlen_over_r <= 1'b0;
                        wbeat_r     <= 8'd0;
                        bid_r       <= S_AXI_AWID;
                        awready_r   <= 1'b0;
                        wready_r    <= 1'b1;
                        w_state_r   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        awaddr_r <= next_addr(awaddr_r, awburst_r);
                        wbeat_r  <= wbeat_r + 8'd1;
                        if (w_oor_s) begin
                            wdec_r <= 1'b1;
                        end
                        if (S_AXI_WLAST) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            w_state_r <= W_RESP;
                            if (wbad_r || wlen_over_r || (wbeat_r != awlen_r)) begin
                                bresp_r <= RESP_SLVERR;
                            end else if (wdec_r || w_oor_s) begin
                                bresp_r <= RESP_DECERR;
                            end else begin
                                bresp_r <= RESP_OKAY;
                            end
                        end else if (wbeat_r == awlen_r) begin
                            // More beats follow the last expected one; sticky so a
                            // wrapped beat counter cannot hide the overrun.
                            wlen_over_r <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_r && S_AXI_BREADY) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane memory writes; contents intentionally survive reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[awaddr_r[IDX_W+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Select the beat to load: the AR request itself when idle, else the next burst beat.
    always_comb begin
        ld_addr_s  = araddr_r;
        ld_burst_s = arburst_r;
        ld_bad_s   = rbad_r;
        if (r_state_r == R_IDLE) begin
            ld_addr_s  = S_AXI_ARADDR;
            ld_burst_s = S_AXI_ARBURST;
            ld_bad_s   = req_bad(S_AXI_ARBURST, S_AXI_ARSIZE);
        end else begin
            ld_addr_s  = araddr_r;
            ld_burst_s = arburst_r;
            ld_bad_s   = rbad_r;
        end
    end

    assign ld_oor_s  = addr_oor(ld_addr_s);
    assign ld_word_s = mem[ld_addr_s[IDX_W+1:2]];

    // Beat data and response, with errors forcing zero data.
    always_comb begin
        ld_data_s = 32'd0;
        ld_resp_s = RESP_OKAY;
        if (ld_bad_s) begin
            ld_data_s = 32'd0;
            ld_resp_s = RESP_SLVERR;
        end else if (ld_oor_s) begin
            ld_data_s = 32'd0;
            ld_resp_s = RESP_DECERR;
        end else begin
            ld_data_s = ld_word_s;
            ld_resp_s = RESP_OKAY;
        end
    end

    // Read FSM: AR capture and registered R beats.
    // RDATA is sampled from memory with non-blocking semantics, so a same-edge
    // write to the same word is not yet visible (pre-write data is returned).
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_r <= R_IDLE;
            araddr_r  <= '0;
            arlen_r   <= 8'd0;
            arburst_r <= 2'b00;
            rbeat_r   <= 8'd0;
            rbad_r    <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= 2'b00;
            rdata_r   <= 32'd0;
            rid_r     <= '0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    arready_r <= 1'b1;
                    if (arready_r && S_AXI_ARVALID) begin
                        rid_r     <= S_AXI_ARID;
                        arlen_r   <= S_AXI_ARLEN;
                        arburst_r <= S_AXI_ARBURST;
                        rbad_r    <= ld_bad_s;
                        araddr_r  <= next_addr(ld_addr_s, ld_burst_s);
                        rbeat_r   <= 8'd0;
                        rdata_r   <= ld_data_s;
                        rresp_r   <= ld_resp_s;
                        rlast_r   <= (S_AXI_ARLEN == 8'd0);
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid_r && S_AXI_RREADY) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            rdata_r  <= ld_data_s;
                            rresp_r  <= ld_resp_s;
                            araddr_r <= next_addr(araddr_r, arburst_r);
                            rbeat_r  <= rbeat_r + 8'd1;
                            rlast_r  <= ((rbeat_r + 8'd1) == arlen_r);
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_BID     = bid_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RLAST   = rlast_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RID     = rid_r;

endmodule

// File: tb/tb_axi_slave_full_mem.sv
// tb_axi_slave_full_mem
// Directed-vector bench for axi_slave_full_mem. Stimulus tasks push expected
// B and R responses into queues; a negedge monitor pops and compares them on
// every handshake and checks R stability while stalled.
module tb_axi_slave_full_mem;

    localparam int IDW  = 1;
    localparam int AW   = 32;
    localparam int MEMW = 1024;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [IDW-1:0] awid, bid, arid, rid;
    logic [AW-1:0]  awaddr, araddr;
    logic [7:0]     awlen, arlen;
    logic [2:0]     awsize, arsize;
    logic [1:0]     awburst, arburst, bresp, rresp;
    logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rlast, rvalid, rready;
    logic [31:0]    wdata, rdata;
    logic [3:0]     wstrb;

    always #5 clk = ~clk;

    axi_slave_full_mem #(
        .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(32), .C_MEM_WORDS(MEMW)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [IDW-1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    b_exp_t bq[$];
    r_exp_t rq[$];

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rdat [16];
    logic [1:0]  rrsp [16];
    logic        rr_toggle = 1'b0;

    // Monitor state for the stall-stability check
    logic        stalled = 1'b0;
    logic [31:0] st_data;
    logic        st_last;
    logic [1:0]  st_resp;

    // Scoreboard monitor: compare every B and R handshake against the queues.
    always @(negedge clk) begin
        b_exp_t be;
        r_exp_t re;
        if (rst_n && bvalid && bready) begin
            if (bq.size() == 0) begin
                chk("b_unexpected_bvalid", 32'(bvalid), 32'd0);
            end else begin
                be = bq.pop_front();
                chk("bid", 32'(bid), 32'(be.id));
                chk("bresp", 32'(bresp), 32'(be.resp));
            end
        end
        if (rst_n && rvalid && stalled) begin
            chk("rdata_stall_stable", rdata, st_data);
            chk("rlast_stall_stable", 32'(rlast), 32'(st_last));
            chk("rresp_stall_stable", 32'(rresp), 32'(st_resp));
        end
        if (rst_n && rvalid && rready) begin
            if (rq.size() == 0) begin
                chk("r_unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                re = rq.pop_front();
                chk("rid", 32'(rid), 32'(re.id));
                chk("rdata", rdata, re.data);
                chk("rresp", 32'(rresp), 32'(re.resp));
                chk("rlast", 32'(rlast), 32'(re.last));
            end
        end
        stalled = rst_n && rvalid && !rready;
        st_data = rdata;
        st_last = rlast;
        st_resp = rresp;
    end

    // RREADY driver: constantly high, or toggling every cycle for stall tests.
    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rready = rr_toggle ? ~rready : 1'b1;
        end
    end

    task automatic do_aw(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && t < 200) begin t++; @(negedge clk); end
        chk("awready_wait", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == n - 1); wvalid = 1'b1;
            @(negedge clk);
            while (!wready && t < 200) begin t++; @(negedge clk); end
            chk("wready_wait", 32'(wready), 32'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic write_burst(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int n,
                               input logic [1:0] exp_resp);
        int t = 0;
        bq.push_back('{id: id, resp: exp_resp});
        do_aw(id, addr, len, size, burst);
        do_w(n);
        while (bq.size() != 0 && t < 200) begin t++; @(posedge clk); end
        chk("b_timeout", 32'(bq.size()), 32'd0);
        #1;
    endtask

    task automatic read_burst(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int n);
        int t = 0;
        for (int i = 0; i < n; i++) rq.push_back('{id: id, data: rdat[i], resp: rrsp[i], last: (i == n - 1)});
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 200) begin t++; @(negedge clk); end
        chk("arready_wait", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid_latency", 32'(rvalid), 32'd1);
        t = 0;
        while (rq.size() != 0 && t < 400) begin t++; @(posedge clk); end
        chk("r_timeout", 32'(rq.size()), 32'd0);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_awready"}, 32'(awready), 32'd0);
        chk({tag, "_wready"},  32'(wready),  32'd0);
        chk({tag, "_bvalid"},  32'(bvalid),  32'd0);
        chk({tag, "_arready"}, 32'(arready), 32'd0);
        chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
        chk({tag, "_rlast"},   32'(rlast),   32'd0);
        chk({tag, "_bresp"},   32'(bresp),   32'd0);
        chk({tag, "_rresp"},   32'(rresp),   32'd0);
        chk({tag, "_bid"},     32'(bid),     32'd0);
        chk({tag, "_rid"},     32'(rid),     32'd0);
        chk({tag, "_rdata"},   rdata,        32'd0);
    endtask

    // Release reset mid-cycle; the READYs must rise on the first edge after.
    task automatic release_reset(input string tag);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_awready_before_edge"}, 32'(awready), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_awready_after_edge"}, 32'(awready), 32'd1);
        chk({tag, "_arready_after_edge"}, 32'(arready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        release_reset("release");

        // Four-beat INCR write then read back
        wbuf[0] = 32'h0000_0011; wbuf[1] = 32'h0000_0022; wbuf[2] = 32'h0000_0033; wbuf[3] = 32'h0000_0044;
        for (int i = 0; i < 16; i++) sbuf[i] = 4'hF;
        write_burst(1'b1, 32'h0, 8'd3, 3'd2, INCR, 4, OKAY);
        rdat[0] = 32'h0000_0011; rdat[1] = 32'h0000_0022; rdat[2] = 32'h0000_0033; rdat[3] = 32'h0000_0044;
        for (int i = 0; i < 16; i++) rrsp[i] = OKAY;
        read_burst(1'b1, 32'h0, 8'd3, 3'd2, INCR, 4);

        // Partial strobe merge
        wbuf[0] = 32'hAABB_CCDD;
        write_burst(1'b0, 32'h10, 8'd0, 3'd2, INCR, 1, OKAY);
        wbuf[0] = 32'h0000_1234; sbuf[0] = 4'h3;
        write_burst(1'b0, 32'h10, 8'd0, 3'd2, INCR, 1, OKAY);
        sbuf[0] = 4'hF;
        rdat[0] = 32'hAABB_1234;
        read_burst(1'b0, 32'h10, 8'd0, 3'd2, INCR, 1);

        // Eight-beat read with RREADY toggling
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + 32'(i);
        write_burst(1'b1, 32'h20, 8'd7, 3'd2, INCR, 8, OKAY);
        for (int i = 0; i < 8; i++) rdat[i] = 32'hA0 + 32'(i);
        rr_toggle = 1'b1;
        read_burst(1'b1, 32'h20, 8'd7, 3'd2, INCR, 8);
        rr_toggle = 1'b0;
        @(posedge clk); #1;

        // WRAP write rejected, memory untouched
        wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'hDEAD_BEEF;
        write_burst(1'b0, 32'h10, 8'd1, 3'd2, WRAP, 2, SLVERR);
        rdat[0] = 32'hAABB_1234;
        read_burst(1'b0, 32'h10, 8'd0, 3'd2, INCR, 1);

        // Read at the first out-of-range word
        rdat[0] = 32'h0; rrsp[0] = DECERR;
        read_burst(1'b1, 32'h1000, 8'd0, 3'd2, INCR, 1);

        // Burst crossing the top of memory: beat 0 lands, beat 1 decodes out
        wbuf[0] = 32'h0F0F_0F0F; wbuf[1] = 32'h1111_1111;
        write_burst(1'b0, 32'hFFC, 8'd1, 3'd2, INCR, 2, DECERR);
        rdat[0] = 32'h0F0F_0F0F; rrsp[0] = OKAY; rdat[1] = 32'h0; rrsp[1] = DECERR;
        read_burst(1'b0, 32'hFFC, 8'd1, 3'd2, INCR, 2);

        // Unsupported read size: every beat SLVERR with zero data
        rdat[0] = 32'h0; rrsp[0] = SLVERR; rdat[1] = 32'h0; rrsp[1] = SLVERR;
        read_burst(1'b1, 32'h0, 8'd1, 3'd1, INCR, 2);

        // Early WLAST: SLVERR but the beat stays written
        wbuf[0] = 32'h0000_0077;
        write_burst(1'b1, 32'h40, 8'd1, 3'd2, INCR, 1, SLVERR);
        rdat[0] = 32'h0000_0077; rrsp[0] = OKAY;
        read_burst(1'b1, 32'h40, 8'd0, 3'd2, INCR, 1);

        // FIXED write: both beats land on one word, last wins
        wbuf[0] = 32'h1234_5678; wbuf[1] = 32'h8765_4321;
        write_burst(1'b0, 32'h44, 8'd1, 3'd2, FIXED, 2, OKAY);
        rdat[0] = 32'h8765_4321; rdat[1] = 32'h8765_4321; rrsp[1] = OKAY;
        read_burst(1'b0, 32'h44, 8'd1, 3'd2, FIXED, 2);

        // Concurrent 16-beat write and 16-beat read to disjoint regions
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h2000 + 32'(i);
        write_burst(1'b0, 32'h300, 8'd15, 3'd2, INCR, 16, OKAY);
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = 32'h1000 + 32'(i);
            rdat[i] = 32'h2000 + 32'(i);
            rrsp[i] = OKAY;
        end
        fork
            write_burst(1'b1, 32'h200, 8'd15, 3'd2, INCR, 16, OKAY);
            read_burst(1'b0, 32'h300, 8'd15, 3'd2, INCR, 16);
        join
        for (int i = 0; i < 16; i++) rdat[i] = 32'h1000 + 32'(i);
        read_burst(1'b1, 32'h200, 8'd15, 3'd2, INCR, 16);

        // Reset while beat 2 of a 4-beat write is on the bus
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5150_0000 + 32'(i);
        do_aw(1'b1, 32'h100, 8'd3, 3'd2, INCR);
        do_w(2);
        wdata = wbuf[2]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midburst_reset");
        wvalid = 1'b0;
        release_reset("midburst_release");
        repeat (3) @(posedge clk);
        #1;
        chk("no_b_after_reset", 32'(bvalid), 32'd0);
        rdat[0] = 32'h5150_0000; rdat[1] = 32'h5150_0001;
        read_burst(1'b0, 32'h100, 8'd1, 3'd2, INCR, 2);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_slave_full_mem.md
AXI_SLAVE_FULL_MEM -- requirements
Module: axi_slave_full_mem

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width; 32 is the only supported value.
REQ-004 SHALL have parameter C_MEM_WORDS, default 1024, memory depth in 32-bit words; power of two.
REQ-005 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port S_AXI_ARESETN, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have the AW channel ports:
- S_AXI_AWID, input, ID width.
- S_AXI_AWADDR, input, ADDR width.
- S_AXI_AWLEN, input, 8.
- S_AXI_AWSIZE, input, 3.
- S_AXI_AWBURST, input, 2.
- S_AXI_AWVALID, input, 1.
- S_AXI_AWREADY, output, 1.
REQ-008 SHALL have the W channel ports:
- S_AXI_WDATA, input, 32.
- S_AXI_WSTRB, input, 4.
- S_AXI_WLAST, input, 1.
- S_AXI_WVALID, input, 1.
- S_AXI_WREADY, output, 1.
REQ-009 SHALL have the B channel ports:
- S_AXI_BID, output, ID width.
- S_AXI_BRESP, output, 2.
- S_AXI_BVALID, output, 1.
- S_AXI_BREADY, input, 1.
REQ-010 SHALL have AR channel ports S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID and S_AXI_ARREADY, with the same directions and widths as their AW counterparts.
REQ-011 SHALL have the R channel ports:
- S_AXI_RID, output, ID width.
- S_AXI_RDATA, output, 32.
- S_AXI_RRESP, output, 2.
- S_AXI_RLAST, output, 1.
- S_AXI_RVALID, output, 1.
- S_AXI_RREADY, input, 1.

Function
REQ-012 SHALL implement a byte-addressed memory of C_MEM_WORDS x 32, indexed by address bits [log2(C_MEM_WORDS)+1:2]; address bits [1:0] are ignored.
REQ-013 Write FSM SHALL have the states W_IDLE, W_DATA and W_RESP:
- W_IDLE: AWREADY=1. An AW handshake captures ID, address, LEN and BURST, then moves to W_DATA.
- W_DATA: WREADY=1. Each W handshake writes only the bytes whose WSTRB bit is set, then advances the address.
- A W handshake with WLAST=1 moves to W_RESP.
- W_RESP: BVALID=1 and BID = the captured AWID. A B handshake returns to W_IDLE.
REQ-014 Write address advance SHALL be: INCR adds 4 per beat; FIXED holds the address. Address wrap-around at the top of ADDR width is permitted.
REQ-015 BRESP SHALL be SLVERR (2'b10) in either case:
- AWBURST=WRAP or reserved; no memory write occurs.
- AWSIZE is not 3'b010; no memory write occurs.
- The beat count at WLAST differs from AWLEN+1; beats already written remain written.
REQ-016 BRESP SHALL be DECERR (2'b11) if any beat address is at or above C_MEM_WORDS*4; that beat is not written. Otherwise BRESP SHALL be OKAY. SLVERR takes precedence over DECERR.
REQ-017 Read FSM SHALL have the states R_IDLE and R_DATA:
- R_IDLE: ARREADY=1. An AR handshake in cycle N captures the request.
- RVALID SHALL assert in cycle N+1 with registered RDATA for beat 0.
- RID SHALL equal the captured ARID throughout the burst.
- RLAST=1 only on beat ARLEN.
REQ-018 R outputs SHALL hold stable while RVALID=1 and RREADY=0. An R handshake loads the next beat in the same edge, so a continuously asserted RREADY yields one beat per cycle. The handshake on the RLAST beat returns the FSM to R_IDLE.
REQ-019 Read error responses SHALL be:
- Unsupported ARBURST or ARSIZE: every beat returns RDATA=0 with RRESP=SLVERR.
- Out-of-range beat: RDATA=0 with RRESP=DECERR.
- Otherwise RRESP=OKAY.
REQ-020 Read and write FSMs SHALL operate independently and concurrently, with at most one outstanding burst each.
REQ-021 Same-cycle write and read-beat load to the same word SHALL return the pre-write data.
REQ-022 READY outputs SHALL NOT depend combinationally on VALID inputs.

Reset
REQ-023 On ARESETN=0, regardless of the clock, the following SHALL be forced immediately:
- AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST to 0.
- BRESP, RRESP, BID, RID and RDATA to 0.
- Both FSMs to their IDLE states.
REQ-024 AWREADY and ARREADY SHALL assert on the first rising edge after ARESETN deasserts.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 Reset mid-burst SHALL abandon the burst with no B or R response produced. Beats written before reset remain in memory.

Verification
REQ-027 Bench SHALL cover: AW addr 0x0, LEN=3, INCR, SIZE=2, data 0x11..0x44, WSTRB=0xF -> BRESP=OKAY, BID echoed; then AR same -> 4 beats 0x11,0x22,0x33,0x44, RLAST on beat 3, first RVALID 1 cycle after AR handshake.
REQ-028 Bench SHALL cover: write 0xAABBCCDD to 0x10 then WSTRB=0x3 data 0x00001234 -> read 0x10 returns 0xAABB1234.
REQ-029 Bench SHALL cover: read LEN=7 with RREADY toggling every other cycle -> 8 beats, RDATA/RLAST stable while stalled, no beat lost or duplicated.
REQ-030 Bench SHALL cover: AWBURST=WRAP, LEN=1 -> BRESP=SLVERR, memory unchanged; AR at C_MEM_WORDS*4 -> RRESP=DECERR, RDATA=0.
REQ-031 Bench SHALL cover: concurrent 16-beat write and 16-beat read to disjoint regions -> both complete with OKAY and correct data.
REQ-032 Bench SHALL cover: ARESETN low during beat 2 of a 4-beat write -> all outputs 0 immediately, no BVALID, AWREADY=1 one edge after release, beats 0-1 present in memory.
